// File: rtl/led_pkg.sv
// Shared constants and types for the multi-channel LED PWM driver.
package led_pkg;
  localparam int CFG_CHAN_W = 4;
  localparam int MODE_W     = 3;

  typedef enum logic [MODE_W-1:0] {
    LED_OFF     = 3'd0,
    LED_ON      = 3'd1,
    LED_PWM     = 3'd2,
    LED_BLINK   = 3'd3,
    LED_BREATHE = 3'd4
  } led_mode_t;
endpackage

// File: rtl/led_pwm_ctrl_if.sv
// Configuration write port of the LED driver.
// valid/ready: a write transfers on every clock edge where cfg_valid && cfg_ready;
// the master holds chan/mode/duty stable while cfg_valid is high.
interface led_pwm_ctrl_if #(
  parameter int PWM_BITS = 8
);
  import led_pkg::*;

  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [CFG_CHAN_W-1:0] cfg_chan;
  logic [MODE_W-1:0]     cfg_mode;
  logic [PWM_BITS-1:0]   cfg_duty;

  modport master (output cfg_valid, cfg_chan, cfg_mode, cfg_duty, input cfg_ready);
  modport slave  (input cfg_valid, cfg_chan, cfg_mode, cfg_duty, output cfg_ready);
endinterface

// File: rtl/led_pwm_channel.sv
// One LED channel: shadow/active config, breathe scaling, duty compare and pin flop.
module led_pwm_channel
  import led_pkg::*;
#(
  parameter int PWM_BITS   = 8,
  parameter int BLINK_BITS = 9,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [MODE_W-1:0]     wr_mode,
  input  logic [PWM_BITS-1:0]   wr_duty,
  input  logic                  bound,
  input  logic [PWM_BITS-1:0]   pwm_cnt,
  input  logic [BLINK_BITS-1:0] blink_cnt,
  output logic                  led
);
  localparam logic POL = (ACTIVE_LOW != 0);
  // A short blink counter is left-aligned so the ramp still spans a full blink cycle.
  localparam int RW = (BLINK_BITS > PWM_BITS) ? BLINK_BITS : PWM_BITS + 1;

  led_mode_t             shadow_mode, act_mode;
  logic [PWM_BITS-1:0]   shadow_duty, act_duty;
  logic [RW-1:0]         ext;
  logic [PWM_BITS:0]     r;
  logic [PWM_BITS-1:0]   ramp;
  logic [2*PWM_BITS-1:0] prod;
  logic [PWM_BITS-1:0]   eff_duty;
  logic                  phase;
  logic                  lit;

  assign ext      = RW'(blink_cnt) << (RW - BLINK_BITS);
  assign r        = ext[RW-1 -: PWM_BITS+1];
  assign ramp     = r[PWM_BITS] ? ~r[PWM_BITS-1:0] : r[PWM_BITS-1:0];
  assign prod     = {{PWM_BITS{1'b0}}, ramp} * {{PWM_BITS{1'b0}}, act_duty};
  assign eff_duty = prod[2*PWM_BITS-1:PWM_BITS];
  assign phase    = blink_cnt[BLINK_BITS-1];

  always_comb begin
    lit = 1'b0;
    case (act_mode)
      LED_ON:      lit = 1'b1;
      LED_PWM:     lit = (act_duty > pwm_cnt);
      LED_BLINK:   lit = (act_duty > pwm_cnt) && !phase;
      LED_BREATHE: lit = (eff_duty > pwm_cnt);
      default:     lit = 1'b0;
    endcase
  end

  // On a write coinciding with bound, active takes the pre-write shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_mode <= LED_OFF;
      shadow_duty <= '0;
      act_mode    <= LED_OFF;
      act_duty    <= '0;
      led         <= POL;
    end else begin
      if (wr) begin
        shadow_mode <= led_mode_t'(wr_mode);
        shadow_duty <= wr_duty;
      end
      if (bound) begin
        act_mode <= shadow_mode;
        act_duty <= shadow_duty;
      end
      led <= lit ^ POL;
    end
  end
endmodule

// File: rtl/led_pwm_ctrl.sv
// Multi-channel LED driver: shared prescaler/PWM/blink counters, config decode, channel array.
module led_pwm_ctrl
  import led_pkg::*;
#(
  parameter int CHANNELS   = 3,
  parameter int PWM_BITS   = 8,
  parameter int PRESCALE   = 188,
  parameter int BLINK_BITS = 9,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                clk48,
  input  logic                rst,
  led_pwm_ctrl_if.slave       cfg,
  output logic [CHANNELS-1:0] led,
  output logic                period_stb
);
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PRE_W-1:0]      pre_cnt;
  logic [PWM_BITS-1:0]   pwm_cnt;
  logic [BLINK_BITS-1:0] blink_cnt;
  logic                  rdy;
  logic                  tick;
  logic                  bound;
  logic                  accept;

  assign tick          = (pre_cnt == PRE_W'(PRESCALE - 1));
  assign bound         = tick && (pwm_cnt == '1);
  assign cfg.cfg_ready = rdy && !rst;
  assign accept        = cfg.cfg_valid && cfg.cfg_ready;

  always_ff @(posedge clk48) begin
    if (rst) begin
      pre_cnt    <= '0;
      pwm_cnt    <= '0;
      blink_cnt  <= '0;
      rdy        <= 1'b0;
      period_stb <= 1'b0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
      if (tick)  pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
      if (bound) blink_cnt <= blink_cnt + BLINK_BITS'(1);
      rdy        <= 1'b1;
      period_stb <= bound;
    end
  end

  // Writes to channels at or above CHANNELS match no decoder and are dropped.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    led_pwm_channel #(
      .PWM_BITS   (PWM_BITS),
      .BLINK_BITS (BLINK_BITS),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_chan (
      .clk       (clk48),
      .rst       (rst),
      .wr        (accept && (cfg.cfg_chan == CFG_CHAN_W'(i))),
      .wr_mode   (cfg.cfg_mode),
      .wr_duty   (cfg.cfg_duty),
      .bound     (bound),
      .pwm_cnt   (pwm_cnt),
      .blink_cnt (blink_cnt),
      .led       (led[i])
    );
  end
endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Self-checking bench for led_pwm_ctrl against a cycle-count based behavioural model.
module tb_led_pwm_ctrl;
  localparam int CH         = 3;
  localparam int PWM_BITS   = 4;
  localparam int PRESCALE   = 2;
  localparam int BLINK_BITS = 3;
  localparam int PERIOD     = PRESCALE * (1 << PWM_BITS);
  localparam int BLINK_LEN  = 1 << BLINK_BITS;

  logic          clk48 = 1'b0;
  logic          rst   = 1'b1;
  logic [CH-1:0] led;
  logic          period_stb;

  int checks   = 0;
  int failures = 0;
  logic [5:0] exp_q[$];

  led_pwm_ctrl_if #(.PWM_BITS(PWM_BITS)) cfg_if ();

  led_pwm_ctrl #(
    .CHANNELS   (CH),
    .PWM_BITS   (PWM_BITS),
    .PRESCALE   (PRESCALE),
    .BLINK_BITS (BLINK_BITS),
    .ACTIVE_LOW (1)
  ) dut (
    .clk48      (clk48),
    .rst        (rst),
    .cfg        (cfg_if),
    .led        (led),
    .period_stb (period_stb)
  );

  always #5 clk48 = ~clk48;

  // ---------------- reference model ----------------
  int            m_cyc = 0;
  logic          m_rdy = 1'b0;
  logic [2:0]    sh_mode[CH];
  logic [3:0]    sh_duty[CH];
  logic [2:0]    ac_mode[CH];
  logic [3:0]    ac_duty[CH];
  logic [CH-1:0] exp_led = '1;
  logic          exp_stb = 1'b0;
  logic          exp_ready;

  assign exp_ready = m_rdy && !rst;

  function automatic logic [CH-1:0] model_led(input int cyc);
    int pwm, blink, ramp, eff;
    logic lit;
    logic [CH-1:0] v;
    pwm   = (cyc / PRESCALE) % (1 << PWM_BITS);
    blink = (cyc / PERIOD) % BLINK_LEN;
    ramp  = blink * 32 / BLINK_LEN;
    ramp  = (ramp < 16) ? ramp : 31 - ramp;
    v = '1;
    for (int c = 0; c < CH; c++) begin
      eff = ramp * int'(ac_duty[c]) / 16;
      case (ac_mode[c])
        3'd1:    lit = 1'b1;
        3'd2:    lit = int'(ac_duty[c]) > pwm;
        3'd3:    lit = (int'(ac_duty[c]) > pwm) && (blink < BLINK_LEN / 2);
        3'd4:    lit = eff > pwm;
        default: lit = 1'b0;
      endcase
      v[c] = !lit;
    end
    return v;
  endfunction

  always @(posedge clk48) begin
    if (rst) begin
      m_cyc   <= 0;
      m_rdy   <= 1'b0;
      exp_led <= '1;
      exp_stb <= 1'b0;
      for (int c = 0; c < CH; c++) begin
        sh_mode[c] <= '0; sh_duty[c] <= '0;
        ac_mode[c] <= '0; ac_duty[c] <= '0;
      end
    end else begin
      exp_led <= model_led(m_cyc);
      exp_stb <= (m_cyc % PERIOD) == PERIOD - 1;
      if ((m_cyc % PERIOD) == PERIOD - 1)
        for (int c = 0; c < CH; c++) begin
          ac_mode[c] <= sh_mode[c];
          ac_duty[c] <= sh_duty[c];
        end
      if (cfg_if.cfg_valid && m_rdy && (int'(cfg_if.cfg_chan) < CH)) begin
        sh_mode[cfg_if.cfg_chan] <= cfg_if.cfg_mode;
        sh_duty[cfg_if.cfg_chan] <= cfg_if.cfg_duty;
      end
      m_cyc <= m_cyc + 1;
      m_rdy <= 1'b1;
    end
  end

  // ---------------- drivers ----------------
  task automatic cfg_write(input int chan, input int mode, input int duty);
    @(negedge clk48);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_chan  = 4'(chan);
    cfg_if.cfg_mode  = 3'(mode);
    cfg_if.cfg_duty  = 4'(duty);
    @(negedge clk48);
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic wait_stb();
    for (int k = 0; k < 2 * PERIOD; k++) begin
      @(negedge clk48);
      if (exp_stb) break;
    end
  endtask

  task automatic wait_phase(input int ph);
    for (int k = 0; k < 2 * PERIOD; k++) begin
      if ((m_cyc % PERIOD) == ph) break;
      @(negedge clk48);
    end
  endtask

  // Counts lit cycles of one channel over a period and cycles disagreeing with the model.
  task automatic measure(input int ch, output int lows, output int bad);
    lows = 0;
    bad  = 0;
    for (int k = 0; k < PERIOD; k++) begin
      @(negedge clk48);
      if (led[ch] == 1'b0) lows++;
      if (led !== exp_led || period_stb !== exp_stb || cfg_if.cfg_ready !== exp_ready) bad++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk48);
      checks++;
      if (led !== 3'b111 || cfg_if.cfg_ready !== 1'b0 || period_stb !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold led=%b ready=%b stb=%b required led=111 ready=0 stb=0",
                 led, cfg_if.cfg_ready, period_stb);
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (cfg_if.cfg_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_first_cycle ready=%b required 0", cfg_if.cfg_ready);
    end
    @(negedge clk48);
    checks++;
    if (cfg_if.cfg_ready !== 1'b1 || led !== 3'b111) begin
      failures++;
      $display("FAIL ready_second_cycle ready=%b led=%b required ready=1 led=111",
               cfg_if.cfg_ready, led);
    end
  endtask

  task automatic test_pwm_duty();
    int duties[3] = '{4, 0, 15};
    int want[3]   = '{8, 0, 30};
    int lows, bad;
    for (int i = 0; i < 3; i++) begin
      cfg_write(0, 2, duties[i]);
      wait_stb();
      wait_stb();
      measure(0, lows, bad);
      checks++;
      if (lows != want[i] || bad != 0) begin
        failures++;
        $display("FAIL pwm_duty%0d lit_cycles=%0d model_mismatches=%0d required %0d and 0",
                 duties[i], lows, bad, want[i]);
      end
    end
  endtask

  task automatic test_commit();
    int lows, bad;
    wait_phase(PERIOD - 1);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_chan  = 4'd1;
    cfg_if.cfg_mode  = 3'd1;
    cfg_if.cfg_duty  = 4'd0;
    @(negedge clk48);
    cfg_if.cfg_valid = 1'b0;
    measure(1, lows, bad);
    checks++;
    if (lows != 0 || bad != 0) begin
      failures++;
      $display("FAIL commit_same_period lit_cycles=%0d model_mismatches=%0d required 0 and 0", lows, bad);
    end
    measure(1, lows, bad);
    checks++;
    if (lows != PERIOD || bad != 0) begin
      failures++;
      $display("FAIL commit_next_period lit_cycles=%0d model_mismatches=%0d required %0d and 0",
               lows, bad, PERIOD);
    end
    cfg_write(1, 0, 0);
    wait_stb();
    wait_stb();
    wait_phase(5);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_chan  = 4'd1;
    cfg_if.cfg_mode  = 3'd1;
    @(negedge clk48);
    cfg_if.cfg_mode  = 3'd0;
    @(negedge clk48);
    cfg_if.cfg_valid = 1'b0;
    wait_stb();
    wait_stb();
    measure(1, lows, bad);
    checks++;
    if (lows != 0 || bad != 0) begin
      failures++;
      $display("FAIL commit_last_wins lit_cycles=%0d model_mismatches=%0d required 0 and 0", lows, bad);
    end
  endtask

  task automatic test_blink();
    int lows, bad, b, want;
    cfg_write(2, 3, 15);
    wait_stb();
    wait_stb();
    for (int j = 0; j < BLINK_LEN; j++) begin
      b = (m_cyc / PERIOD) % BLINK_LEN;
      want = (b < BLINK_LEN / 2) ? 30 : 0;
      measure(2, lows, bad);
      checks++;
      if (lows != want || bad != 0) begin
        failures++;
        $display("FAIL blink_period%0d lit_cycles=%0d model_mismatches=%0d required %0d and 0",
                 b, lows, bad, want);
      end
    end
  endtask

  task automatic test_breathe();
    int eff_tbl[8] = '{0, 3, 7, 11, 14, 10, 6, 2};
    int lows, bad, b0;
    logic [5:0] want;
    cfg_write(0, 4, 15);
    wait_stb();
    wait_stb();
    b0 = (m_cyc / PERIOD) % BLINK_LEN;
    for (int j = 0; j < BLINK_LEN; j++) exp_q.push_back(6'(eff_tbl[(b0 + j) % BLINK_LEN] * PRESCALE));
    for (int j = 0; j < BLINK_LEN; j++) begin
      want = exp_q.pop_front();
      measure(0, lows, bad);
      checks++;
      if (lows != int'(want) || bad != 0) begin
        failures++;
        $display("FAIL breathe_step%0d lit_cycles=%0d model_mismatches=%0d required %0d and 0",
                 j, lows, bad, want);
      end
    end
    @(negedge clk48);
    checks++;
    if (cfg_if.cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL chan7_ready ready=%b required 1", cfg_if.cfg_ready);
    end
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_chan  = 4'd7;
    cfg_if.cfg_mode  = 3'd1;
    cfg_if.cfg_duty  = 4'(15);
    @(negedge clk48);
    cfg_if.cfg_valid = 1'b0;
    wait_stb();
    wait_stb();
    measure(1, lows, bad);
    checks++;
    if (lows != 0 || bad != 0) begin
      failures++;
      $display("FAIL chan7_discard lit_cycles=%0d model_mismatches=%0d required 0 and 0", lows, bad);
    end
  endtask

  task automatic test_mid_reset();
    int lows, bad;
    for (int c = 0; c < CH; c++) cfg_write(c, 1, $urandom_range(0, 15));
    wait_stb();
    wait_stb();
    @(negedge clk48);
    checks++;
    if (led !== 3'b000) begin
      failures++;
      $display("FAIL all_on led=%b required 000", led);
    end
    cfg_write(0, 2, $urandom_range(1, 15));
    wait_phase(13);
    rst = 1'b1;
    @(negedge clk48);
    checks++;
    if (led !== 3'b111 || period_stb !== 1'b0 || cfg_if.cfg_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset led=%b stb=%b ready=%b required 111 0 0",
               led, period_stb, cfg_if.cfg_ready);
    end
    @(negedge clk48);
    rst = 1'b0;
    wait_stb();
    wait_stb();
    for (int c = 0; c < CH; c++) begin
      measure(c, lows, bad);
      checks++;
      if (lows != 0 || bad != 0) begin
        failures++;
        $display("FAIL post_reset_ch%0d lit_cycles=%0d model_mismatches=%0d required 0 and 0",
                 c, lows, bad);
      end
    end
  endtask

  task automatic test_random();
    int lows, bad;
    for (int n = 0; n < 4; n++) begin
      cfg_write($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 15));
      wait_stb();
      measure(n % CH, lows, bad);
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL random_%0d model_mismatches=%0d required 0", n, bad);
      end
    end
  endtask

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_chan  = '0;
    cfg_if.cfg_mode  = '0;
    cfg_if.cfg_duty  = '0;
    test_reset();
    test_pwm_duty();
    test_commit();
    test_blink();
    test_breathe();
    test_random();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/led_pwm_ctrl.md
# led_pwm_ctrl

Parametrised multi-channel LED driver for the RGB LED and other indicator pins. It replaces free-running counter-bit blinkers with per-channel modes: off, on, PWM dimming, blinking and breathing. Channels are configured at run time through a valid/ready write port, and new settings take effect glitch-free at the next PWM period boundary. It sits at the top level between status logic (PLL lock, heartbeat, user state) and the `rgb_led0_*` pins.

## Interface
- `CHANNELS`, 3: number of LED outputs, 1..16.
- `PWM_BITS`, 8: duty resolution; PWM period is 2^PWM_BITS ticks.
- `PRESCALE`, 188: `clk48` cycles per PWM tick, ≥1 (≈1 kHz PWM at 48 MHz with 8 bits).
- `BLINK_BITS`, 9: width of the period counter that drives blink and breathe.
- `ACTIVE_LOW`, 1: 1 means a lit LED drives the pin 0.

Ports:
- `clk48`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_valid`  in  1  configuration write request.
- `cfg_ready`  out  1  write accepted when `cfg_valid && cfg_ready`.
- `cfg_chan`  in  4  target channel.
- `cfg_mode`  in  3  mode code.
- `cfg_duty`  in  PWM_BITS  brightness.
- `led`  out  CHANNELS  registered pin drive, with polarity per `ACTIVE_LOW`.
- `period_stb`  out  1  one-cycle pulse at each PWM period boundary.

## Operation
- **Mode codes:**
  - 0 OFF
  - 1 ON, full-on, ignores duty
  - 2 PWM
  - 3 BLINK, PWM gated by blink phase
  - 4 BREATHE, duty is a triangle ramp scaled by `cfg_duty`
  - 5..7 treated as OFF
- **Prescaler:** `pre_cnt` counts 0..PRESCALE-1 and wraps. `tick` is asserted in the cycle where `pre_cnt == PRESCALE-1`.
- **PWM counter:** `pwm_cnt` (PWM_BITS) increments on `tick` and wraps naturally.
- **Period boundary:** `bound = tick && pwm_cnt == all-ones`.
- **Blink counter:** `blink_cnt` (BLINK_BITS) increments on `bound` and wraps. Blink phase is `blink_cnt[BLINK_BITS-1]`: 0 = lit, 1 = dark.
- **Breathe ramp:**
  - `r` = `blink_cnt` top PWM_BITS+1 bits.
  - `tri` = `r[MSB] ? ~r[PWM_BITS-1:0] : r[PWM_BITS-1:0]`.
  - Effective duty = (`tri` × `cfg_duty`) >> PWM_BITS, computed unsigned in 2×PWM_BITS bits.
- **Config storage:** each channel has a shadow {mode, duty} and an active {mode, duty}.
  - An accepted write updates the shadow only.
  - On `bound`, every active copy loads its shadow.
  - A write accepted in the same cycle as `bound` lands in the shadow. The active copy takes the pre-write shadow, so the new value applies at the following boundary.
  - Two writes to the same channel before a boundary: the last one wins.
  - A write with `cfg_chan ≥ CHANNELS` is accepted and discarded.
- **Handshake:** `cfg_ready` = 0 during reset and in the first cycle after `rst` deasserts; 1 otherwise. No backpressure beyond that.
- **Lit decision (per channel, from active config):**
  - OFF: 0
  - ON: 1
  - PWM: `duty > pwm_cnt`
  - BLINK: `duty > pwm_cnt` AND phase = 0
  - BREATHE: `eff_duty > pwm_cnt`
  - Consequence: duty 0 is always dark; duty all-ones is lit 255/256 of the period.
- **Pin drive:** `led[i] = lit ^ ACTIVE_LOW`.

## Timing
- Reset clears `pre_cnt`, `pwm_cnt`, `blink_cnt`, all shadows and all active copies. Every `led` bit is held at `ACTIVE_LOW` (dark), `period_stb` is 0, and `cfg_ready` is 0.
- `rst` asserted mid-period takes effect on the next edge: all LEDs go dark and pending shadows are lost.
- `led` is registered, with one cycle of latency from the counter state to the pin.
- `period_stb` is registered and asserted in the cycle after `bound`, which is the same cycle the new active config first influences `led`.
- First PWM period after reset: `pwm_cnt = 0` starts at the first post-reset edge.
- Period length is exactly PRESCALE × 2^PWM_BITS cycles. Blink full cycle is 2^BLINK_BITS periods.

## Structure
- Package `led_pkg`: mode code constants (`LED_OFF` .. `LED_BREATHE`), mode type, and the `CFG_CHAN_W=4` constant.
- Sub-module `led_pwm_channel`: one instance per channel. It holds the shadow/active registers, the breathe multiply, the compare and the output flop.
- The top level keeps the shared prescaler, `pwm_cnt`, `blink_cnt`, handshake and channel decode.

## Test plan
Bench settings: `PRESCALE=2`, `PWM_BITS=4`, `BLINK_BITS=3`, `CHANNELS=3`, `ACTIVE_LOW=1`. This gives a 32-cycle period.

1. **Reset values:** hold `rst` for 5 cycles → `led=3'b111`, `cfg_ready=0`, `period_stb=0`. After release, `cfg_ready` goes to 1 on the second cycle.
2. **PWM duty:** write ch0 PWM duty 4 → after the next `period_stb`, ch0 pin is 0 for 8 of 32 cycles per period. Duty 0 gives pin constant 1; duty 15 gives pin low 30 of 32 cycles.
3. **Commit timing:** write ch1 ON in the same cycle as `bound` → ch1 is unchanged for that period and lights only after the following `period_stb`. Two writes (ON, then OFF) before a boundary → ch1 stays dark.
4. **Blink:** write ch2 BLINK duty 15 → PWM pulses for 4 periods, then dark for 4 periods, repeating every 256 cycles.
5. **Breathe:** write BREATHE duty 15 → effective duty sequence over the blink cycle follows the triangle and returns to 0 at wrap. Also write `cfg_chan=7` → accepted, and no channel changes.
6. **Mid-operation reset:** assert `rst` mid-period with all channels ON → `led=3'b111` on the next edge. After release, all channels stay OFF until rewritten.
